// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage core: prioritises stage stall
// requests, sequences multi-cycle EX operations and counts stalled cycles.
module pipe_stall_ctrl #(
    parameter int MC_LEN_W = 6,
    parameter int ADDR_W   = 32,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                flush_req,
    input  logic [ADDR_W-1:0]   flush_pc,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [ADDR_W-1:0]   new_pc,
    output logic                ex_mc_busy,
    output logic                ex_mc_done,
    output logic [PERF_W-1:0]   stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_RUN  = 2'd1,
        ST_MC_DONE = 2'd2
    } state_t;

    localparam logic [MC_LEN_W-1:0] CNT_ONE  = MC_LEN_W'(1);
    localparam logic [PERF_W-1:0]   PERF_MAX = {PERF_W{1'b1}};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [MC_LEN_W-1:0] cnt_r;
    logic [MC_LEN_W-1:0] cnt_nxt_s;
    logic                start_s;
    logic                ex_stall_s;

    // Accepted multi-cycle start; a coincident flush drops it.
    assign start_s    = (state_r == ST_IDLE) && ex_mc_start && !flush_req;
    assign ex_stall_s = start_s || (state_r == ST_MC_RUN);

    // State and cycle counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (flush_req) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_mc_start) begin
                        // A length of 0 behaves like 1: a single stalled cycle.
                        if (ex_mc_len <= CNT_ONE) begin
                            state_nxt_s = ST_MC_DONE;
                        end else begin
                            cnt_nxt_s   = ex_mc_len - CNT_ONE;
                            state_nxt_s = ST_MC_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MC_RUN: begin
                    if (cnt_r == CNT_ONE) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_MC_DONE;
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
                ST_MC_DONE: begin
                    if (stallreq_mem) begin
                        state_nxt_s = ST_MC_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // Stall/flush outputs are combinational so stage registers see them at the same edge.
    always_comb begin
        stall      = 6'b000000;
        flush      = 1'b0;
        new_pc     = '0;
        ex_mc_busy = 1'b0;
        ex_mc_done = 1'b0;
        if (!rst) begin
            stall = 6'b000000;
        end else if (flush_req) begin
            flush  = 1'b1;
            new_pc = flush_pc;
        end else begin
            ex_mc_busy = ex_stall_s;
            ex_mc_done = (state_r == ST_MC_DONE);
            if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (ex_stall_s) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end else if (stallreq_if) begin
                stall = 6'b000011;
            end else begin
                stall = 6'b000000;
            end
        end
    end

    // Saturating stalled-cycle counter; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((stall != 6'b000000) && (stall_cycles != PERF_MAX)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end else begin
            stall_cycles <= stall_cycles;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: each driven cycle pushes its expected
// outputs, which are popped and compared once the combinational outputs settle.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_len;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_mc_busy;
    logic        ex_mc_done;
    logic [15:0] stall_cycles;

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        busy;
        logic        done;
        logic [15:0] perf;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    logic [15:0] perf_exp;

    pipe_stall_ctrl #(.MC_LEN_W(6), .ADDR_W(32), .PERF_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_len    (ex_mc_len),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .ex_mc_busy   (ex_mc_busy),
        .ex_mc_done   (ex_mc_done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic f_if, input logic f_id, input logic f_mem,
                          input logic st, input logic [5:0] len,
                          input logic fr, input logic [31:0] fpc);
        stallreq_if  = f_if;
        stallreq_id  = f_id;
        stallreq_mem = f_mem;
        ex_mc_start  = st;
        ex_mc_len    = len;
        flush_req    = fr;
        flush_pc     = fpc;
    endtask

    // Push the expected outputs of this cycle, let them settle, then pop and compare.
    task automatic cyc(input string tag, input logic [5:0] s, input logic f,
                       input logic [31:0] pc, input logic b, input logic d);
        exp_t e;
        exp_t o;
        e.tag = tag; e.stall = s; e.flush = f; e.new_pc = pc;
        e.busy = b; e.done = d; e.perf = perf_exp;
        sb_q.push_back(e);
        #2;
        o = sb_q.pop_front();
        check_val({o.tag, ".stall"}, 64'(stall),        64'(o.stall));
        check_val({o.tag, ".flush"}, 64'(flush),        64'(o.flush));
        check_val({o.tag, ".pc"},    64'(new_pc),       64'(o.new_pc));
        check_val({o.tag, ".busy"},  64'(ex_mc_busy),   64'(o.busy));
        check_val({o.tag, ".done"},  64'(ex_mc_done),   64'(o.done));
        check_val({o.tag, ".perf"},  64'(stall_cycles), 64'(o.perf));
        if (rst && (s != 6'b000000)) perf_exp = perf_exp + 16'd1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        perf_exp = 16'd0;
        rst      = 1'b0;
        // Requests driven during reset must not reach the outputs.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 32'h1234_5678);
        @(negedge clk);
        cyc("rst_hold", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) cyc("idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

        // len=3: three EX-stalled cycles, then done, then idle
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 32'h0);
        cyc("mc3_start", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("mc3_run2", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc("mc3_run1", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc("mc3_done", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("mc3_idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        check_val("mc3_perf", 64'(stall_cycles), 64'd3);

        // len=1 and len=0: one stalled cycle then done
        for (int l = 1; l >= 0; l--) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 6'(l), 1'b0, 32'h0);
            cyc("mc_short_start", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
            cyc("mc_short_done", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
            cyc("mc_short_idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        end

        // Request priority
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("prio_if", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("prio_id", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("prio_mem", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 32'hBFC0_0380);
        cyc("prio_flush", 6'b000000, 1'b1, 32'hBFC0_0380, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'hBFC0_0380);
        cyc("prio_none", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Start coincident with flush is dropped
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b1, 32'h0000_0100);
        cyc("startflush", 6'b000000, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("startflush_idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

        // len=10 aborted by flush at cnt=5; a stray start mid-run is ignored
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0, 32'h0);
        cyc("mc10_start", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int c = 9; c > 5; c--) begin
            set_in(1'b0, 1'b0, 1'b0, (c == 7), 6'd1, 1'b0, 32'h0);
            cyc("mc10_run", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h8000_0180);
        cyc("mc10_flush", 6'b000000, 1'b1, 32'h8000_0180, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("mc10_idle0", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("mc10_idle1", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

        // len=2 after the abort, MEM stall in run and held 3 cycles in done
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 32'h0);
        cyc("mc2_start", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("mc2_run_mem", 6'b011111, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc("mc2_done_mem", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("mc2_done_rel", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("mc2_idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        check_val("mc2_perf", 64'(stall_cycles), 64'(perf_exp));

        // Reset in the middle of a run
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 32'h0);
        cyc("mc8_start", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        cyc("mc8_run", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        rst      = 1'b0;
        perf_exp = 16'd0;
        cyc("mc8_rst", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) cyc("mc8_after", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline controller for the 5-stage core. It arbitrates stall requests from the IF, ID, EX and MEM stages and sequences multi-cycle EX operations (div, madd/msub) with an internal cycle counter. It issues flushes on exception or redirect. Its stall[5:0] bus drives every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb); flush clears them.

Parameters:
MC_LEN_W, 6, width of the multi-cycle length field and internal counter
ADDR_W, 32, width of the PC redirect address
PERF_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
stallreq_if  in  1  fetch bus wait
stallreq_id  in  1  ID load-use hazard
stallreq_mem  in  1  MEM bus wait
ex_mc_start  in  1  EX begins a multi-cycle op (one-cycle pulse)
ex_mc_len  in  MC_LEN_W  total EX cycles for the op
flush_req  in  1  exception/redirect request
flush_pc  in  ADDR_W  redirect target
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1=Stop
flush  out  1  clear all pipeline registers this cycle
new_pc  out  ADDR_W  redirect target, valid when flush=1
ex_mc_busy  out  1  multi-cycle op in progress
ex_mc_done  out  1  EX result may be taken this cycle
stall_cycles  out  PERF_W  count of cycles with stall!=0, saturating

Behaviour:
- Async reset (rst=0): state=IDLE, cnt=0, stall_cycles=0. Combinational outputs evaluate to stall=000000, flush=0, new_pc=0, ex_mc_busy=0, ex_mc_done=0 while reset is held.
- FSM states: IDLE, MC_RUN, MC_DONE. Counter cnt is MC_LEN_W bits.
- IDLE:
  - On ex_mc_start with flush_req=0: if ex_mc_len<=1, go to MC_DONE; otherwise cnt<=ex_mc_len-1 and go to MC_RUN.
  - ex_mc_len=0 is treated as 1.
- MC_RUN:
  - If cnt==1, go to MC_DONE; otherwise cnt<=cnt-1.
  - cnt keeps counting during a MEM stall.
- MC_DONE:
  - ex_mc_done=1.
  - If stallreq_mem=1, stay in MC_DONE with ex_mc_done held high. Otherwise go to IDLE.
- ex_mc_start is ignored outside IDLE.
- EX stall requirement: asserted in the start cycle and in every MC_RUN cycle, for exactly ex_mc_len stalled cycles in total. Not asserted in MC_DONE.
- ex_mc_busy=1 in the start cycle and in MC_RUN.
- stall is combinational from the current state and requests, so the stage registers sample it at the same edge. Priority, highest first:
  - flush_req: stall=000000, flush=1, new_pc=flush_pc.
  - stallreq_mem: 011111.
  - EX stall requirement: 001111.
  - stallreq_id: 000111.
  - stallreq_if: 000011.
  - none: 000000.
- Flush, same cycle: asserted in any state, it forces state to IDLE and cnt to 0 at the next edge and aborts the multi-cycle op. ex_mc_busy and ex_mc_done are forced to 0 in that cycle. A coincident ex_mc_start is dropped.
- new_pc=0 when flush=0.
- stall_cycles increments on every edge where stall!=000000 and saturates at all-ones. Flush does not clear it; only reset does.
- Reset asserted mid-operation returns to IDLE immediately. No done pulse is produced.

Test Plan:
1. Reset release, no requests for 5 cycles -> stall=000000, flush=0, stall_cycles=0 throughout.
2. ex_mc_start with ex_mc_len=3 -> stall=001111 for exactly 3 cycles (start, cnt=2, cnt=1). The next cycle has ex_mc_done=1 and stall=000000, followed by IDLE. stall_cycles=3.
3. ex_mc_len=1 and ex_mc_len=0 -> one stalled cycle, then ex_mc_done for one cycle.
4. stallreq_id and stallreq_if together -> 000111. Add stallreq_mem -> 011111. Add flush_req with flush_pc=0xBFC00380 -> stall=000000, flush=1, new_pc=0xBFC00380.
5. ex_mc_len=10, flush_req in MC_RUN at cnt=5 -> flush=1 that cycle, ex_mc_busy=0, and IDLE next cycle with no ex_mc_done. A later ex_mc_start is accepted.
6. ex_mc_len=2 with stallreq_mem held for 3 cycles starting at MC_DONE -> stall=011111, ex_mc_done stays 1 for all 3 cycles, then IDLE. Also drive rst low for one cycle mid-MC_RUN -> outputs reset immediately.
